// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port among N producers,
// with bounded bursts per owner and a one-cycle flush sequencer.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int WS    = 16,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WS-1:0]      data_in,
  output logic [N-1:0]         gnt,
  input  logic                 flush_req,
  input  logic                 fifo_full,
  output logic                 fifo_push,
  output logic [WS-1:0]        fifo_data,
  output logic                 fifo_flush,
  output logic [$clog2(N)-1:0] src_id
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic [1:0] {ARB, HOLD, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] cnt_inc;

  logic          rr_found;
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] cand;
  int            j;

  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic          flush_now;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    return (i == IW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  // First requester at or after ptr, wrapping modulo N
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      cand = IW'(j);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    grant_vld = 1'b0;
    grant_idx = '0;
    flush_now = 1'b0;
    case (state)
      ARB: begin
        if (flush_req) begin
          state_nxt = FLUSH;
        end else if (!fifo_full && rr_found) begin
          grant_vld = 1'b1;
          grant_idx = rr_idx;
          if (BURST == 1) begin
            ptr_nxt = inc_idx(rr_idx);
          end else begin
            owner_nxt = rr_idx;
            cnt_nxt   = CW'(1);
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush_req) begin
          ptr_nxt   = inc_idx(owner);
          state_nxt = FLUSH;
        end else if (!req[owner]) begin
          ptr_nxt   = inc_idx(owner);
          state_nxt = ARB;
        end else if (!fifo_full) begin
          // A full FIFO stalls the burst without consuming a beat
          grant_vld = 1'b1;
          grant_idx = owner;
          cnt_nxt   = cnt_inc;
          if (cnt_inc == CW'(BURST)) begin
            ptr_nxt   = inc_idx(owner);
            state_nxt = ARB;
          end
        end
      end
      FLUSH: begin
        flush_now = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    gnt        = '0;
    fifo_push  = 1'b0;
    fifo_data  = '0;
    fifo_flush = 1'b0;
    src_id     = '0;
    if (!reset) begin
      fifo_flush = flush_now;
      if (grant_vld) begin
        gnt       = N'(1) << grant_idx;
        fifo_push = 1'b1;
        fifo_data = data_in[grant_idx*WS +: WS];
        src_id    = grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N=4, WS=16, BURST=4).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic [3:0]  gnt;
  logic        flush_req;
  logic        fifo_full;
  logic        fifo_push;
  logic [15:0] fifo_data;
  logic        fifo_flush;
  logic [1:0]  src_id;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arbiter #(.N(4), .WS(16), .BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data_in    (data_in),
    .gnt        (gnt),
    .flush_req  (flush_req),
    .fifo_full  (fifo_full),
    .fifo_push  (fifo_push),
    .fifo_data  (fifo_data),
    .fifo_flush (fifo_flush),
    .src_id     (src_id)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset     = 1'b1;
    req       = 4'b0000;
    flush_req = 1'b0;
    fifo_full = 1'b0;
    data_in   = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; flush_req = 1'b0; fifo_full = 1'b0;
    data_in = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (gnt !== 4'b0000 || fifo_push !== 1'b0 || fifo_flush !== 1'b0 ||
          fifo_data !== 16'h0000 || src_id !== 2'd0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d gnt=%b push=%b flush=%b data=%h src=%0d required all zero",
                 c, gnt, fifo_push, fifo_flush, fifo_data, src_id);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL reset_release gnt=%b required=0001", gnt);
    end
    @(negedge clk);
  endtask

  task automatic test_fair_rotation();
    logic [1:0]  exp_src;
    logic [15:0] exp_data;
    do_reset();
    req     = 4'b1111;
    data_in = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    for (int c = 0; c < 20; c++) begin
      exp_src  = 2'((c / 4) % 4);
      exp_data = 16'hA000 + 16'(exp_src);
      #1;
      checks++;
      if (src_id !== exp_src || fifo_push !== 1'b1 || fifo_data !== exp_data ||
          gnt !== (4'b0001 << exp_src)) begin
        failures++;
        $display("FAIL rotation cyc=%0d src=%0d push=%b data=%h gnt=%b required src=%0d push=1 data=%h",
                 c, src_id, fifo_push, fifo_data, gnt, exp_src, exp_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_owner_drop();
    logic [3:0] exp_gnt [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0100};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req = (c < 2) ? 4'b0001 : 4'b0100;
      #1;
      checks++;
      if (gnt !== exp_gnt[c] || fifo_push !== (exp_gnt[c] != 4'b0000)) begin
        failures++;
        $display("FAIL owner_drop cyc=%0d gnt=%b push=%b required gnt=%b", c, gnt, fifo_push, exp_gnt[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    // beats 1,2 of requester 1; 3 stalled cycles; beats 3,4; then requester 2
    logic       full_v  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] exp_gnt [8] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                4'b0010, 4'b0010, 4'b0100};
    do_reset();
    req = 4'b0110;
    for (int c = 0; c < 8; c++) begin
      fifo_full = full_v[c];
      #1;
      checks++;
      if (gnt !== exp_gnt[c] || fifo_push !== (exp_gnt[c] != 4'b0000)) begin
        failures++;
        $display("FAIL backpressure cyc=%0d gnt=%b push=%b required gnt=%b", c, gnt, fifo_push, exp_gnt[c]);
      end
      @(negedge clk);
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_full_in_arb();
    do_reset();
    req = 4'b1111; fifo_full = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || fifo_push !== 1'b0) begin
      failures++;
      $display("FAIL full_arb gnt=%b push=%b required gnt=0000 push=0", gnt, fifo_push);
    end
    @(negedge clk);
    fifo_full = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL full_arb_release gnt=%b required=0001", gnt);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_mid_burst();
    logic       freq_v  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_gnt [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
    logic       exp_fl  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      flush_req = freq_v[c];
      #1;
      checks++;
      if (gnt !== exp_gnt[c] || fifo_flush !== exp_fl[c]) begin
        failures++;
        $display("FAIL flush cyc=%0d gnt=%b flush=%b required gnt=%b flush=%b",
                 c, gnt, fifo_flush, exp_gnt[c], exp_fl[c]);
      end
      @(negedge clk);
    end
    flush_req = 1'b0;
  endtask

  task automatic test_data_steering();
    do_reset();
    data_in = {16'hBEEF, 16'h2222, 16'h1111, 16'h5555};
    req = 4'b1000;
    #1;
    checks++;
    if (gnt !== 4'b1000 || fifo_data !== 16'hBEEF || src_id !== 2'd3 || fifo_push !== 1'b1) begin
      failures++;
      $display("FAIL steering gnt=%b data=%h src=%0d push=%b required gnt=1000 data=beef src=3 push=1",
               gnt, fifo_data, src_id, fifo_push);
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b0000 || fifo_data !== 16'h0000 || src_id !== 2'd0 || fifo_push !== 1'b0) begin
      failures++;
      $display("FAIL steering_idle gnt=%b data=%h src=%0d push=%b required all zero",
               gnt, fifo_data, src_id, fifo_push);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fair_rotation();
    test_owner_drop();
    test_backpressure();
    test_full_in_arb();
    test_flush_mid_burst();
    test_data_steering();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
